// File: rtl/gate3_pkg.sv
// Shared state encoding, reference truth tables and sizing helper for the 3-input gate sweep checker.
// Truth table bit i is the required gate output for input vector x = i.
package gate3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] TT_AND3  = 8'h80;
    localparam logic [7:0] TT_NAND3 = 8'h7F;
    localparam logic [7:0] TT_OR3   = 8'hFE;
    localparam logic [7:0] TT_XOR3  = 8'h96;

    // The counter may step one past the expiry value before being cleared, so it must hold n.
    function automatic int timer_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: counts enabled cycles, expired flags the last cycle of the settle window.
// Clear and reset force zero; clear wins over enable.
module settle_timer
    import gate3_pkg::*;
#(
    parameter int SETTLE_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = timer_width(SETTLE_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/gate3_sweep_checker.sv
// Sweeps all 8 input vectors through an external 3-input gate, holding each for SETTLE_CYCLES+1 cycles,
// and compares the sampled output against the EXPECT truth table; start is honoured only when idle.
module gate3_sweep_checker
    import gate3_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 5,
    parameter logic [7:0] EXPECT        = TT_AND3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] x,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_idx
);

    state_t     state, state_d;
    logic [2:0] x_d;
    logic [3:0] err_d;
    logic       fv_d;
    logic [2:0] fi_d;
    logic       pass_d;
    logic       tmr_clear;
    logic       tmr_en;
    logic       tmr_expired;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clear),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d   = state;
        x_d       = x;
        err_d     = err_count;
        fv_d      = fail_valid;
        fi_d      = fail_idx;
        pass_d    = pass;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETTLE;
                    x_d       = 3'd0;
                    err_d     = 4'd0;
                    fv_d      = 1'b0;
                    pass_d    = 1'b0;
                    tmr_clear = 1'b1;
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                tmr_clear = 1'b1;
                if (y != EXPECT[x]) begin
                    err_d = err_count + 4'd1;
                    // Only the first mismatch of a sweep is recorded.
                    if (!fail_valid) begin
                        fi_d = x;
                        fv_d = 1'b1;
                    end
                end
                if (x == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    x_d     = x + 3'd1;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                pass_d  = (err_count == 4'd0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            x          <= 3'd0;
            err_count  <= 4'd0;
            fail_valid <= 1'b0;
            fail_idx   <= 3'd0;
            pass       <= 1'b0;
        end else begin
            state      <= state_d;
            x          <= x_d;
            err_count  <= err_d;
            fail_valid <= fv_d;
            fail_idx   <= fi_d;
            pass       <= pass_d;
        end
    end

    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);

endmodule
